// File: rtl/alu_sched.sv
// alu_sched -- two-port round-robin sequencer for the shared ALU; iterates 1-bit SRA into variable shifts.
// Rev 1.0
`default_nettype none

module alu_sched #(
  parameter int unsigned XLEN    = 32,
  parameter int unsigned OPW     = 6,
  parameter int unsigned OP_SRA  = 13,
  parameter int unsigned OP_SRAI = 29
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            req0_valid,
  output logic            req0_ready,
  input  logic [OPW-1:0]  req0_op,
  input  logic [XLEN-1:0] req0_a,
  input  logic [XLEN-1:0] req0_b,
  input  logic            req1_valid,
  output logic            req1_ready,
  input  logic [OPW-1:0]  req1_op,
  input  logic [XLEN-1:0] req1_a,
  input  logic [XLEN-1:0] req1_b,
  output logic            rsp0_valid,
  output logic [XLEN-1:0] rsp0_data,
  output logic            rsp1_valid,
  output logic [XLEN-1:0] rsp1_data,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [OPW-1:0]  alu_op,
  input  logic [XLEN-1:0] alu_result,
  output logic            busy
);

  typedef enum logic [1:0] {IDLE, EXEC, SHIFT, RESP} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic            port_q, port_d;
  logic [OPW-1:0]  op_q, op_d;
  logic [XLEN-1:0] a_q, a_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] acc_q, acc_d;
  logic [4:0]      cnt_q, cnt_d;

  logic            is_sra;
  logic [4:0]      shamt;

  assign is_sra = (op_q == OPW'(OP_SRA)) || (op_q == OPW'(OP_SRAI));
  assign shamt  = b_q[4:0];
  assign busy   = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      port_q  <= 1'b0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      port_q  <= port_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    last_d     = last_q;
    port_d     = port_q;
    op_d       = op_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp0_data  = '0;
    rsp1_valid = 1'b0;
    rsp1_data  = '0;
    alu_op     = '0;
    alu_a      = '0;
    alu_b      = '0;
    case (state_q)
      IDLE: begin
        // rst_n gating keeps both readies low while reset is held
        req0_ready = rst_n & req0_valid & (~req1_valid | last_q);
        req1_ready = rst_n & req1_valid & (~req0_valid | ~last_q);
        if (req0_ready) begin
          port_d  = 1'b0;
          last_d  = 1'b0;
          op_d    = req0_op;
          a_d     = req0_a;
          b_d     = req0_b;
          state_d = EXEC;
        end else if (req1_ready) begin
          port_d  = 1'b1;
          last_d  = 1'b1;
          op_d    = req1_op;
          a_d     = req1_a;
          b_d     = req1_b;
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (!is_sra) begin
          alu_op  = op_q;
          alu_a   = a_q;
          alu_b   = b_q;
          acc_d   = alu_result;
          state_d = RESP;
        end else if (shamt == 5'd0) begin
          acc_d   = a_q;
          state_d = RESP;
        end else begin
          alu_op  = OPW'(OP_SRA);
          alu_a   = a_q;
          acc_d   = alu_result;
          cnt_d   = shamt - 5'd1;
          state_d = (shamt == 5'd1) ? RESP : SHIFT;
        end
      end
      SHIFT: begin
        alu_op = OPW'(OP_SRA);
        alu_a  = acc_q;
        acc_d  = alu_result;
        cnt_d  = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        if (port_q) begin
          rsp1_valid = 1'b1;
          rsp1_data  = acc_q;
        end else begin
          rsp0_valid = 1'b1;
          rsp0_data  = acc_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

`default_nettype wire
